da_regfile_ctrl: RTL and testbench
==================================

Name: da_regfile_ctrl

Overview:
- Address/sequencing controller that turns the 8-entry complex register file into a programmable sample delay line (1..8 valid beats) for SDF-style FFT stages.
- Accepts a valid-qualified sample stream and drives the regfile write/read enables and addresses.
- Produces out_valid aligned with the regfile's registered read data.
- Supports an explicit flush that drains the samples still held in the file.

Parameters:
ADDR_W, 3, regfile address width; depth is 2**ADDR_W = 8 (only 3 is supported).
DLY_W, 4, width of cfg_delay (must represent 1..8).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  sample present on regfile din this cycle.
in_ready  output  1  controller accepts in_valid this cycle.
cfg_delay  input  DLY_W  requested delay in valid beats; sampled only on the IDLE start beat.
flush  input  1  single-cycle request to drain held samples.
rf_wen  output  1  regfile write enable.
rf_waddr  output  ADDR_W  regfile write address.
rf_ren  output  1  regfile read enable.
rf_raddr  output  ADDR_W  regfile read address.
out_valid  output  1  regfile dout valid this cycle (rf_ren delayed 1 cycle).
count  output  DLY_W  entries currently held (0..8).
busy  output  1  state != IDLE.

Behaviour:
- Outputs rf_wen, rf_ren, rf_waddr, rf_raddr are combinational from state, pointers and in_valid. out_valid, count, pointers and state are registered.
- Reset: state=IDLE, wptr=rptr=0, count=0, delay_q=1, out_valid=0, busy=0, in_ready=1, rf_wen=rf_ren=0, addresses=0.
- A reset asserted mid-operation abandons all held data. The next cycle is IDLE.
- Delay clamp: delay_q = 1 if cfg_delay==0; 8 if cfg_delay>8; else cfg_delay.
- Accept condition: acc = in_valid & in_ready. in_ready = 1 in IDLE, FILL and STREAM; 0 in DRAIN.
- IDLE:
  - acc → latch delay_q from clamped cfg_delay; write at wptr=0; count=1.
  - Next state is STREAM if delay_q==1, else FILL.
  - flush in IDLE is ignored.
- FILL:
  - acc → rf_wen=1, waddr=wptr, wptr++ (mod 8), count++.
  - When count reaches delay_q, go to STREAM. No reads in FILL.
- STREAM:
  - acc → rf_wen=1 at wptr and rf_ren=1 at rptr in the same cycle; both pointers ++ (mod 8); count unchanged (=delay_q).
  - Invariant: rptr = (wptr - delay_q) mod 8, so each output is the sample accepted delay_q beats earlier.
  - delay_q==8 gives rptr==wptr. The regfile returns the old contents on a same-address read/write, which is the required behaviour.
  - No acc → no read, no write.
- Flush (from FILL or STREAM):
  - If acc coincides with flush, that beat is processed normally first.
  - The next state is DRAIN, or IDLE if count is 0 after that beat.
- DRAIN:
  - Each cycle: rf_ren=1 at rptr, rptr++, count--.
  - The cycle that reads the last entry (count 1→0) transitions to IDLE.
  - On entry to IDLE: wptr=rptr=0.
  - in_valid is ignored (in_ready=0). A further flush is ignored.
- out_valid(t+1) = rf_ren(t). When rf_ren=0 the regfile drives dout=0; downstream must qualify with out_valid.
- Pointers wrap 7→0 with no special handling.
- Changing cfg_delay outside the IDLE start beat has no effect.

Test Plan:
- Reset, cfg_delay=3, in_valid held high with samples 1,2,3,... → wen on cycles 0-2 only (FILL); from beat 3 on, wen+ren together; out_valid first high one cycle after beat 3 carrying sample 1; output k+3 carries sample k+1; count stays 3.
- cfg_delay=8, 20 continuous beats → raddr==waddr in STREAM; outputs are samples 1..12 in order, each 8 beats late; pointer wrap 7→0 observed.
- cfg_delay=0 and cfg_delay=12 → behave as delay 1 (STREAM immediately after the first beat) and delay 8 respectively.
- cfg_delay=4, input gaps (valid 1,0,1,1,0,1,1,1) → delay counted in valid beats; no reads on idle cycles; sample 1 emerges on the 5th valid beat.
- cfg_delay=5, 7 beats then flush coinciding with an 8th valid beat → beat 8 accepted; DRAIN emits samples 4..8 on 5 consecutive cycles; in_ready=0 during DRAIN; returns to IDLE with count=0 and busy=0.
- Assert rst for 1 cycle in the middle of STREAM and then in the middle of DRAIN → next cycle IDLE, all outputs at reset values; a fresh stream restarts at waddr 0.

Source files
------------

// File: rtl/da_regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : da_regfile_ctrl
// Description : Address/sequencing controller that turns an 8-entry register
//               file into a programmable 1..8 valid-beat sample delay line,
//               with an explicit flush that drains the held samples.
// Revision    : 1.0 - initial release
// ============================================================================
module da_regfile_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DLY_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic              flush,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic              rf_ren,
    output logic [ADDR_W-1:0] rf_raddr,
    output logic              out_valid,
    output logic [DLY_W-1:0]  count,
    output logic              busy
);

    localparam int               c_DEPTH   = 1 << ADDR_W;
    localparam logic [DLY_W-1:0] c_DEPTH_D = DLY_W'(c_DEPTH);
    localparam logic [DLY_W-1:0] c_CNT_ONE = DLY_W'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FILL   = 2'd1;
    localparam logic [1:0] c_STREAM = 2'd2;
    localparam logic [1:0] c_DRAIN  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [DLY_W-1:0]  r_count;
    logic [DLY_W-1:0]  r_delay;
    logic              r_out_valid;

    logic              w_acc;
    logic [DLY_W-1:0]  w_delay_clamp;
    logic              w_fill_done;

    // Handshake and regfile strobes are decoded straight from state/pointers
    assign in_ready  = (r_state != c_DRAIN);
    assign w_acc     = in_valid & in_ready;
    assign rf_wen    = w_acc;
    assign rf_waddr  = r_wptr;
    assign rf_ren    = ((r_state == c_STREAM) && w_acc) || (r_state == c_DRAIN);
    assign rf_raddr  = r_rptr;
    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign busy      = (r_state != c_IDLE);

    // FILL ends on the beat that brings the occupancy up to the programmed delay
    assign w_fill_done = ((r_count + c_CNT_ONE) == r_delay);

    // Clamp the requested delay into the legal 1..depth range
    always_comb begin
        w_delay_clamp = cfg_delay;
        if (cfg_delay == '0) begin
            w_delay_clamp = c_CNT_ONE;
        end else if (cfg_delay > c_DEPTH_D) begin
            w_delay_clamp = c_DEPTH_D;
        end
    end

    // Sequencer: pointers, occupancy, latched delay and state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_delay     <= c_CNT_ONE;
            r_out_valid <= 1'b0;
        end else begin
            // Regfile read data is registered, so valid trails the read by one cycle
            r_out_valid <= rf_ren;
            case (r_state)
                c_IDLE: begin
                    // Flush is meaningless with nothing held; only a sample starts a run
                    if (w_acc) begin
                        r_delay <= w_delay_clamp;
                        r_wptr  <= r_wptr + c_PTR_ONE;
                        r_count <= c_CNT_ONE;
                        r_state <= (w_delay_clamp == c_CNT_ONE) ? c_STREAM : c_FILL;
                    end
                end
                c_FILL: begin
                    if (w_acc) begin
                        r_wptr  <= r_wptr + c_PTR_ONE;
                        r_count <= r_count + c_CNT_ONE;
                    end
                    // At least one entry is always held here, so flush always drains
                    if (flush) begin
                        r_state <= c_DRAIN;
                    end else if (w_acc && w_fill_done) begin
                        r_state <= c_STREAM;
                    end
                end
                c_STREAM: begin
                    // Write and read advance together, keeping rptr = wptr - delay
                    if (w_acc) begin
                        r_wptr <= r_wptr + c_PTR_ONE;
                        r_rptr <= r_rptr + c_PTR_ONE;
                    end
                    if (flush) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    r_rptr  <= r_rptr + c_PTR_ONE;
                    r_count <= r_count - c_CNT_ONE;
                    if (r_count <= c_CNT_ONE) begin
                        r_state <= c_IDLE;
                        r_wptr  <= '0;
                        r_rptr  <= '0;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_da_regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_da_regfile_ctrl
// Description : Directed, table-driven bench for da_regfile_ctrl with a small
//               behavioural regfile so sample data through the delay is visible.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_da_regfile_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cfg_delay;
    logic       flush;
    logic       rf_wen;
    logic [2:0] rf_waddr;
    logic       rf_ren;
    logic [2:0] rf_raddr;
    logic       out_valid;
    logic [3:0] count;
    logic       busy;
    logic [7:0] din;

    da_regfile_ctrl #(.ADDR_W(3), .DLY_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cfg_delay (cfg_delay),
        .flush     (flush),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_ren    (rf_ren),
        .rf_raddr  (rf_raddr),
        .out_valid (out_valid),
        .count     (count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered read, old data on same-address read/write
    logic [7:0] mem [8];
    logic [7:0] dout;
    always @(posedge clk) begin
        if (rf_wen) mem[rf_waddr] <= din;
        dout <= rf_ren ? mem[rf_raddr] : 8'd0;
    end

    typedef struct {
        logic       rs, iv, fl;
        logic [3:0] cfg;
        logic [7:0] dn;
        logic       rdy, wen;
        logic [2:0] wa;
        logic       ren;
        logic [2:0] ra;
        logic       ov;
        logic [7:0] dv;
        logic [3:0] cnt;
        logic       bsy;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t v(int rs, int iv, int fl, int cfg, int dn,
                               int rdy, int wen, int wa, int ren, int ra,
                               int ov, int dv, int cnt, int bsy);
        vec_t r;
        r.rs = rs[0]; r.iv = iv[0]; r.fl = fl[0]; r.cfg = 4'(cfg); r.dn = 8'(dn);
        r.rdy = rdy[0]; r.wen = wen[0]; r.wa = 3'(wa); r.ren = ren[0]; r.ra = 3'(ra);
        r.ov = ov[0]; r.dv = 8'(dv); r.cnt = 4'(cnt); r.bsy = bsy[0];
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic fl, input logic [3:0] cfg, input logic [7:0] dn);
        rst = r; in_valid = iv; flush = fl; cfg_delay = cfg; din = dn;
    endtask

    // Long delay run: beats carry samples 1..20, then flush and drain 8 entries
    task automatic run8(input logic [3:0] cfg);
        int base;
        base = 1000 + 100 * int'(cfg);
        for (int b = 0; b < 20; b++) begin
            drive(1'b0, 1'b1, 1'b0, cfg, 8'(b + 1));
            #1;
            n_vec++;
            chk("d8_waddr", base + b, 8'(rf_waddr), 8'(b % 8));
            chk("d8_ren", base + b, 8'(rf_ren), 8'(b >= 8));
            if (b >= 8) chk("d8_raddr", base + b, 8'(rf_raddr), 8'(b % 8));
            chk("d8_ovalid", base + b, 8'(out_valid), 8'(b >= 9));
            if (b >= 9) chk("d8_data", base + b, dout, 8'(b - 8));
            chk("d8_count", base + b, 8'(count), 8'((b < 8) ? b : 8));
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b1, cfg, 8'd0);
        #1;
        n_vec++;
        chk("d8_fl_ren", base + 20, 8'(rf_ren), 8'd0);
        chk("d8_fl_data", base + 20, dout, 8'd12);
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            drive(1'b0, 1'b1, 1'b0, cfg, 8'hAA);
            #1;
            n_vec++;
            chk("d8_dr_ready", base + 30 + j, 8'(in_ready), 8'd0);
            chk("d8_dr_wen", base + 30 + j, 8'(rf_wen), 8'd0);
            chk("d8_dr_ren", base + 30 + j, 8'(rf_ren), 8'd1);
            chk("d8_dr_raddr", base + 30 + j, 8'(rf_raddr), 8'((12 + j) % 8));
            chk("d8_dr_count", base + 30 + j, 8'(count), 8'(8 - j));
            chk("d8_dr_ovalid", base + 30 + j, 8'(out_valid), 8'(j >= 1));
            if (j >= 1) chk("d8_dr_data", base + 30 + j, dout, 8'(12 + j));
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, cfg, 8'd0);
        #1;
        n_vec++;
        chk("d8_end_data", base + 40, dout, 8'd20);
        chk("d8_end_ovalid", base + 40, 8'(out_valid), 8'd1);
        chk("d8_end_busy", base + 40, 8'(busy), 8'd0);
        chk("d8_end_count", base + 40, 8'(count), 8'd0);
        @(negedge clk);
    endtask

    initial begin
        // rs iv fl cfg din | rdy wen wa ren ra | ov dout cnt busy
        // delay 3, continuous beats, idle cycles, flush/drain, flush in IDLE
        vq.push_back(v(0,1,0,3,1,   1,1,0,0,0, 0,0,0,0));
        vq.push_back(v(0,1,0,3,2,   1,1,1,0,0, 0,0,1,1));
        vq.push_back(v(0,1,0,3,3,   1,1,2,0,0, 0,0,2,1));
        vq.push_back(v(0,1,0,3,4,   1,1,3,1,0, 0,0,3,1));
        vq.push_back(v(0,1,0,3,5,   1,1,4,1,1, 1,1,3,1));
        vq.push_back(v(0,1,0,3,6,   1,1,5,1,2, 1,2,3,1));
        vq.push_back(v(0,1,0,3,7,   1,1,6,1,3, 1,3,3,1));
        vq.push_back(v(0,0,0,3,0,   1,0,7,0,4, 1,4,3,1));
        vq.push_back(v(0,0,0,3,0,   1,0,7,0,4, 0,0,3,1));
        vq.push_back(v(0,0,1,3,0,   1,0,7,0,4, 0,0,3,1));
        vq.push_back(v(0,1,0,3,99,  0,0,7,1,4, 0,0,3,1));
        vq.push_back(v(0,0,1,3,0,   0,0,7,1,5, 1,5,2,1));
        vq.push_back(v(0,0,0,3,0,   0,0,7,1,6, 1,6,1,1));
        vq.push_back(v(0,0,0,3,0,   1,0,0,0,0, 1,7,0,0));
        vq.push_back(v(0,0,1,3,0,   1,0,0,0,0, 0,0,0,0));
        // cfg_delay 0 behaves as delay 1; later cfg changes are ignored
        vq.push_back(v(0,1,0,0,10,  1,1,0,0,0, 0,0,0,0));
        vq.push_back(v(0,1,0,5,11,  1,1,1,1,0, 0,0,1,1));
        vq.push_back(v(0,1,0,5,12,  1,1,2,1,1, 1,10,1,1));
        vq.push_back(v(0,0,1,5,0,   1,0,3,0,2, 1,11,1,1));
        vq.push_back(v(0,0,0,5,0,   0,0,3,1,2, 0,0,1,1));
        vq.push_back(v(0,0,0,5,0,   1,0,0,0,0, 1,12,0,0));
        // delay 4 with input gaps, then reset in STREAM
        vq.push_back(v(0,1,0,4,1,   1,1,0,0,0, 0,0,0,0));
        vq.push_back(v(0,0,0,4,238, 1,0,1,0,0, 0,0,1,1));
        vq.push_back(v(0,1,0,4,2,   1,1,1,0,0, 0,0,1,1));
        vq.push_back(v(0,1,0,4,3,   1,1,2,0,0, 0,0,2,1));
        vq.push_back(v(0,0,0,4,238, 1,0,3,0,0, 0,0,3,1));
        vq.push_back(v(0,1,0,4,4,   1,1,3,0,0, 0,0,3,1));
        vq.push_back(v(0,1,0,4,5,   1,1,4,1,0, 0,0,4,1));
        vq.push_back(v(0,1,0,4,6,   1,1,5,1,1, 1,1,4,1));
        vq.push_back(v(0,0,0,4,238, 1,0,6,0,2, 1,2,4,1));
        vq.push_back(v(0,0,0,4,238, 1,0,6,0,2, 0,0,4,1));
        vq.push_back(v(1,1,0,4,7,   1,1,6,1,2, 0,0,4,1));
        vq.push_back(v(0,0,0,2,0,   1,0,0,0,0, 0,0,0,0));
        // delay 2 restart at address 0, then reset in DRAIN
        vq.push_back(v(0,1,0,2,21,  1,1,0,0,0, 0,0,0,0));
        vq.push_back(v(0,1,0,2,22,  1,1,1,0,0, 0,0,1,1));
        vq.push_back(v(0,1,0,2,23,  1,1,2,1,0, 0,0,2,1));
        vq.push_back(v(0,0,1,2,0,   1,0,3,0,1, 1,21,2,1));
        vq.push_back(v(0,0,0,2,0,   0,0,3,1,1, 0,0,2,1));
        vq.push_back(v(1,0,0,2,0,   0,0,3,1,2, 1,22,1,1));
        vq.push_back(v(0,0,0,2,0,   1,0,0,0,0, 0,0,0,0));
        // delay 5, flush coincides with the 8th beat, drain emits 4..8
        vq.push_back(v(0,1,0,5,1,   1,1,0,0,0, 0,0,0,0));
        vq.push_back(v(0,1,0,5,2,   1,1,1,0,0, 0,0,1,1));
        vq.push_back(v(0,1,0,5,3,   1,1,2,0,0, 0,0,2,1));
        vq.push_back(v(0,1,0,5,4,   1,1,3,0,0, 0,0,3,1));
        vq.push_back(v(0,1,0,5,5,   1,1,4,0,0, 0,0,4,1));
        vq.push_back(v(0,1,0,5,6,   1,1,5,1,0, 0,0,5,1));
        vq.push_back(v(0,1,0,5,7,   1,1,6,1,1, 1,1,5,1));
        vq.push_back(v(0,1,1,5,8,   1,1,7,1,2, 1,2,5,1));
        vq.push_back(v(0,1,0,5,85,  0,0,0,1,3, 1,3,5,1));
        vq.push_back(v(0,0,0,5,0,   0,0,0,1,4, 1,4,4,1));
        vq.push_back(v(0,0,0,5,0,   0,0,0,1,5, 1,5,3,1));
        vq.push_back(v(0,0,0,5,0,   0,0,0,1,6, 1,6,2,1));
        vq.push_back(v(0,0,0,5,0,   0,0,0,1,7, 1,7,1,1));
        vq.push_back(v(0,0,0,5,0,   1,0,0,0,0, 1,8,0,0));
        vq.push_back(v(0,0,0,5,0,   1,0,0,0,0, 0,0,0,0));

        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        foreach (vq[i]) begin
            drive(vq[i].rs, vq[i].iv, vq[i].fl, vq[i].cfg, vq[i].dn);
            #1;
            n_vec++;
            chk("in_ready", i, 8'(in_ready), 8'(vq[i].rdy));
            chk("rf_wen",   i, 8'(rf_wen),   8'(vq[i].wen));
            chk("rf_waddr", i, 8'(rf_waddr), 8'(vq[i].wa));
            chk("rf_ren",   i, 8'(rf_ren),   8'(vq[i].ren));
            chk("rf_raddr", i, 8'(rf_raddr), 8'(vq[i].ra));
            chk("out_valid", i, 8'(out_valid), 8'(vq[i].ov));
            if (vq[i].ov) chk("data", i, dout, vq[i].dv);
            chk("count",    i, 8'(count),    8'(vq[i].cnt));
            chk("busy",     i, 8'(busy),     8'(vq[i].bsy));
            @(negedge clk);
        end

        run8(4'd8);
        run8(4'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
